// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single data-memory port between the pipeline memory stage
//   (core, c_*) and the program/data loader (l_*). At most one requester is
//   granted per cycle. The winning access is registered onto the memory port,
//   and in-flight reads are tracked so the returned data reaches its owner.
//
// Ports
//   clk, rstn           clock, synchronous active-low reset
//   c_req/l_req         access request
//   c_addr/l_addr       byte address (32b)
//   c_dina/l_dina       write data (64b)
//   c_wea/l_wea         byte write enables, 0 = read (8b)
//   c_gnt/l_gnt         request accepted this cycle (combinational)
//   c_stall             core request refused this cycle
//   c_rvalid/l_rvalid   read data valid for that requester
//   c_rdata/l_rdata     read data (m_doutb passed through)
//   m_en/m_addr/m_dina/m_wea   registered memory-port access
//   m_doutb             memory read data, RD_LAT cycles after a read's m_en
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
   parameter int RD_LAT    = 3,
   parameter int PRIO_MODE = 0,
   parameter int MAX_WAIT  = 15
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        c_req,
   input  logic [31:0] c_addr,
   input  logic [63:0] c_dina,
   input  logic [7:0]  c_wea,
   output logic        c_gnt,
   output logic        c_stall,
   output logic        c_rvalid,
   output logic [63:0] c_rdata,
   input  logic        l_req,
   input  logic [31:0] l_addr,
   input  logic [63:0] l_dina,
   input  logic [7:0]  l_wea,
   output logic        l_gnt,
   output logic        l_rvalid,
   output logic [63:0] l_rdata,
   output logic        m_en,
   output logic [31:0] m_addr,
   output logic [63:0] m_dina,
   output logic [7:0]  m_wea,
   input  logic [63:0] m_doutb
);

   localparam logic       OWN_CORE   = 1'b0;
   localparam logic       OWN_LDR    = 1'b1;
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   logic            last_gnt_q, last_gnt_d;
   logic [7:0]      wait_cnt_q, wait_cnt_d;
   logic            m_en_q,     m_en_d;
   logic [31:0]     m_addr_q,   m_addr_d;
   logic [63:0]     m_dina_q,   m_dina_d;
   logic [7:0]      m_wea_q,    m_wea_d;
   // Read-tag pipeline: stage k is live k+1 cycles after acceptance, so the
   // last stage lines up with m_doutb (RD_LAT cycles after m_en).
   logic [RD_LAT:0] tag_v_q,    tag_v_d;
   logic [RD_LAT:0] tag_o_q,    tag_o_d;

   logic            core_pref;
   logic            core_sel;
   logic            accept;
   logic            win_own;
   logic [31:0]     win_addr;
   logic [63:0]     win_dina;
   logic [7:0]      win_wea;

   // Tie-break: who wins when both request.
   always_comb begin
      core_pref = 1'b0;
      if (PRIO_MODE == 0) begin
         core_pref = (last_gnt_q == OWN_LDR);
      end else begin
         core_pref = (wait_cnt_q != MAX_WAIT_C);
      end
   end

   assign core_sel = c_req & (~l_req | core_pref);
   // Grants are gated by rstn so nothing is accepted while reset is held.
   assign c_gnt    = rstn & core_sel;
   assign l_gnt    = rstn & l_req & ~core_sel;
   assign c_stall  = rstn & c_req & ~c_gnt;
   assign accept   = c_gnt | l_gnt;
   assign win_own  = l_gnt ? OWN_LDR : OWN_CORE;
   assign win_addr = c_gnt ? c_addr : l_addr;
   assign win_dina = c_gnt ? c_dina : l_dina;
   assign win_wea  = c_gnt ? c_wea  : l_wea;

   always_comb begin
      last_gnt_d = last_gnt_q;
      if (accept) begin
         last_gnt_d = win_own;
      end

      // Starvation counter: counts refused loader cycles, saturating.
      wait_cnt_d = wait_cnt_q;
      if (!l_req || l_gnt) begin
         wait_cnt_d = 8'd0;
      end else if (wait_cnt_q < MAX_WAIT_C) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end

      m_en_d   = accept;
      m_wea_d  = accept ? win_wea  : 8'h00;
      m_addr_d = accept ? win_addr : m_addr_q;
      m_dina_d = accept ? win_dina : m_dina_q;

      tag_v_d  = {tag_v_q[RD_LAT-1:0], accept & (win_wea == 8'h00)};
      tag_o_d  = {tag_o_q[RD_LAT-1:0], win_own};
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_gnt_q <= OWN_LDR;
         wait_cnt_q <= 8'd0;
         m_en_q     <= 1'b0;
         m_addr_q   <= 32'd0;
         m_dina_q   <= 64'd0;
         m_wea_q    <= 8'h00;
         tag_v_q    <= '0;
         tag_o_q    <= '0;
      end else begin
         last_gnt_q <= last_gnt_d;
         wait_cnt_q <= wait_cnt_d;
         m_en_q     <= m_en_d;
         m_addr_q   <= m_addr_d;
         m_dina_q   <= m_dina_d;
         m_wea_q    <= m_wea_d;
         tag_v_q    <= tag_v_d;
         tag_o_q    <= tag_o_d;
      end
   end

   assign m_en     = m_en_q;
   assign m_addr   = m_addr_q;
   assign m_dina   = m_dina_q;
   assign m_wea    = m_wea_q;

   assign c_rvalid = tag_v_q[RD_LAT] & (tag_o_q[RD_LAT] == OWN_CORE);
   assign l_rvalid = tag_v_q[RD_LAT] & (tag_o_q[RD_LAT] == OWN_LDR);
   assign c_rdata  = m_doutb;
   assign l_rdata  = m_doutb;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Directed bench. dut0 (round-robin) is driven against a write-first BRAM
//   model; expected read returns are pushed into a scoreboard queue when each
//   request is issued and popped by an independent monitor on every rvalid.
//   dut1 (core priority, MAX_WAIT=15) is used only for the starvation guard.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

   localparam int RD_LAT = 3;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // dut0 signals
   logic        c_req = 1'b0, l_req = 1'b0;
   logic [31:0] c_addr = '0, l_addr = '0;
   logic [63:0] c_dina = '0, l_dina = '0;
   logic [7:0]  c_wea = '0, l_wea = '0;
   logic        c_gnt, c_stall, c_rvalid, l_gnt, l_rvalid;
   logic [63:0] c_rdata, l_rdata;
   logic        m_en;
   logic [31:0] m_addr;
   logic [63:0] m_dina;
   logic [7:0]  m_wea;
   logic [63:0] m_doutb;

   // dut1 signals
   logic        p_c_req = 1'b0, p_l_req = 1'b0;
   logic        p_c_gnt, p_c_stall, p_c_rvalid, p_l_gnt, p_l_rvalid, p_m_en;
   logic [63:0] p_c_rdata, p_l_rdata, p_m_dina;
   logic [31:0] p_m_addr;
   logic [7:0]  p_m_wea;

   dmem_port_arbiter #(.RD_LAT(RD_LAT), .PRIO_MODE(0), .MAX_WAIT(15)) dut0 (
      .clk(clk), .rstn(rstn),
      .c_req(c_req), .c_addr(c_addr), .c_dina(c_dina), .c_wea(c_wea),
      .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .l_req(l_req), .l_addr(l_addr), .l_dina(l_dina), .l_wea(l_wea),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .m_en(m_en), .m_addr(m_addr), .m_dina(m_dina), .m_wea(m_wea),
      .m_doutb(m_doutb)
   );

   dmem_port_arbiter #(.RD_LAT(RD_LAT), .PRIO_MODE(1), .MAX_WAIT(15)) dut1 (
      .clk(clk), .rstn(rstn),
      .c_req(p_c_req), .c_addr(32'h0000_4000), .c_dina(64'd0), .c_wea(8'hFF),
      .c_gnt(p_c_gnt), .c_stall(p_c_stall), .c_rvalid(p_c_rvalid), .c_rdata(p_c_rdata),
      .l_req(p_l_req), .l_addr(32'h0000_5000), .l_dina(64'd0), .l_wea(8'hFF),
      .l_gnt(p_l_gnt), .l_rvalid(p_l_rvalid), .l_rdata(p_l_rdata),
      .m_en(p_m_en), .m_addr(p_m_addr), .m_dina(p_m_dina), .m_wea(p_m_wea),
      .m_doutb(64'd0)
   );

   // ---------------- BRAM model (write-first, RD_LAT pipeline) -------------
   function automatic logic [63:0] pat(input logic [14:0] k);
      return {16'hA5A5, 1'b0, k, 16'h5A5A, 1'b0, ~k};
   endfunction

   logic [63:0] mem [0:32767];
   logic [63:0] rd_pipe [0:RD_LAT-1];
   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = pat(15'(i));
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
   end

   always @(posedge clk) begin
      if (m_en && m_wea != 8'h00) begin
         for (int b = 0; b < 8; b++)
            if (m_wea[b]) mem[m_addr[17:3]][8*b +: 8] <= m_dina[8*b +: 8];
      end
      rd_pipe[0] <= (m_en && m_wea == 8'h00) ? mem[m_addr[17:3]] : 64'd0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign m_doutb = rd_pipe[RD_LAT-1];

   // ---------------- bookkeeping -------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic        owner;   // 0 = core, 1 = loader
      logic [63:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

   task automatic push_exp(input logic owner, input logic [63:0] data);
      exp_t e;
      e.owner = owner;
      e.data  = data;
      e.due   = cyc + 1 + RD_LAT;
      sb.push_back(e);
   endtask

   // ---------------- monitor -----------------------------------------------
   always @(negedge clk) begin
      exp_t e;
      if (c_rvalid || l_rvalid) begin
         chk("rvalid_exclusive", 64'(c_rvalid & l_rvalid), 64'd0);
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_rvalid: got c=%0b l=%0b, expected none (cycle %0d)",
                     c_rvalid, l_rvalid, cyc);
         end else begin
            e = sb.pop_front();
            $display("[TB] rd return owner=%s data=%h cycle=%0d",
                     l_rvalid ? "ldr" : "core", c_rvalid ? c_rdata : l_rdata, cyc);
            chk("rv_owner", 64'(l_rvalid), 64'(e.owner));
            chk("rv_data", l_rvalid ? l_rdata : c_rdata, e.data);
            chk("rv_cycle", 64'(cyc), 64'(e.due));
         end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
         e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("[TB] FAIL missing_rvalid: got none, expected owner=%0b data=%h at cycle %0d",
                  e.owner, e.data, e.due);
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_c(input logic r, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] w);
      c_req = r; c_addr = a; c_dina = d; c_wea = w;
   endtask

   task automatic set_l(input logic r, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] w);
      l_req = r; l_addr = a; l_dina = d; l_wea = w;
   endtask

   task automatic idle();
      c_req = 1'b0;
      l_req = 1'b0;
   endtask

   // ---------------- directed sequence -------------------------------------
   initial begin
      logic [31:0] a;

      // Reset: grants forced low even with a request present.
      rstn = 1'b0;
      tick();
      set_c(1'b1, 32'h0000_0040, 64'd0, 8'h00);
      @(negedge clk);
      chk("rst_c_gnt", 64'(c_gnt), 64'd0);
      chk("rst_c_stall", 64'(c_stall), 64'd0);
      chk("rst_m_en", 64'(m_en), 64'd0);
      chk("rst_m_wea", 64'(m_wea), 64'd0);
      chk("rst_m_addr", 64'(m_addr), 64'd0);
      chk("rst_c_rvalid", 64'(c_rvalid), 64'd0);
      tick();
      rstn = 1'b1;
      idle();

      // Round-robin, both held 4 cycles: core, loader, core, loader.
      tick();
      set_c(1'b1, 32'h0000_1000, 64'h1, 8'hFF);
      set_l(1'b1, 32'h0000_2000, 64'h2, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         $display("[TB] rr cycle %0d c_gnt=%0b l_gnt=%0b", i + 1, c_gnt, l_gnt);
         chk("rr_c_gnt", 64'(c_gnt), 64'(i % 2 == 0));
         chk("rr_l_gnt", 64'(l_gnt), 64'(i % 2 == 1));
         chk("rr_c_stall", 64'(c_stall), 64'(i % 2 == 1));
         if (i > 0) chk("rr_m_addr", 64'(m_addr), (i % 2 == 1) ? 64'h1000 : 64'h2000);
         tick();
      end
      idle();
      @(negedge clk);
      chk("rr_last_m_en", 64'(m_en), 64'd1);
      chk("rr_last_m_addr", 64'(m_addr), 64'h2000);
      tick();
      @(negedge clk);
      chk("idle_m_en", 64'(m_en), 64'd0);
      chk("idle_m_wea", 64'(m_wea), 64'd0);
      chk("idle_m_addr_hold", 64'(m_addr), 64'h2000);

      // Core read alone at 0x100.
      tick();
      set_c(1'b1, 32'h0000_0100, 64'd0, 8'h00);
      @(negedge clk);
      chk("t1_c_gnt", 64'(c_gnt), 64'd1);
      chk("t1_c_stall", 64'(c_stall), 64'd0);
      chk("t1_l_gnt", 64'(l_gnt), 64'd0);
      push_exp(1'b0, 64'hA5A5_0020_5A5A_7FDF);
      tick();
      idle();
      @(negedge clk);
      chk("t1_m_en", 64'(m_en), 64'd1);
      chk("t1_m_addr", 64'(m_addr), 64'h100);
      chk("t1_m_wea", 64'(m_wea), 64'd0);
      for (int i = 0; i < 5; i++) tick();

      // Loader write then core read of the same word next cycle.
      set_l(1'b1, 32'h0000_8000, 64'hDEAD_BEEF_0000_0001, 8'hFF);
      @(negedge clk);
      chk("t4_l_gnt", 64'(l_gnt), 64'd1);
      tick();
      set_l(1'b0, 32'h0, 64'd0, 8'h00);
      set_c(1'b1, 32'h0000_8000, 64'd0, 8'h00);
      @(negedge clk);
      chk("t4_c_gnt", 64'(c_gnt), 64'd1);
      chk("t4_m_wea", 64'(m_wea), 64'hFF);
      push_exp(1'b0, 64'hDEAD_BEEF_0000_0001);
      tick();
      idle();
      for (int i = 0; i < 5; i++) tick();

      // Partial-byte write (low 4 bytes) then core read.
      set_l(1'b1, 32'h0000_8008, 64'h1122_3344_5566_7788, 8'h0F);
      tick();
      set_l(1'b0, 32'h0, 64'd0, 8'h00);
      set_c(1'b1, 32'h0000_8008, 64'd0, 8'h00);
      @(negedge clk);
      chk("bw_c_gnt", 64'(c_gnt), 64'd1);
      push_exp(1'b0, 64'hA5A5_1001_5566_7788);
      tick();
      idle();
      for (int i = 0; i < 5; i++) tick();

      // Alternating core/loader reads, one per cycle.
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            a = 32'h0000_0200 + 32'(8 * i);
            set_l(1'b0, 32'h0, 64'd0, 8'h00);
            set_c(1'b1, a, 64'd0, 8'h00);
         end else begin
            a = 32'h0001_0000 + 32'(8 * i);
            set_c(1'b0, 32'h0, 64'd0, 8'h00);
            set_l(1'b1, a, 64'd0, 8'h00);
         end
         @(negedge clk);
         chk("alt_gnt", 64'((i % 2 == 0) ? c_gnt : l_gnt), 64'd1);
         push_exp(1'(i % 2), pat(a[17:3]));
         tick();
      end
      idle();
      for (int i = 0; i < 6; i++) tick();

      // Read in flight cancelled by a reset pulse two cycles later.
      set_c(1'b1, 32'h0000_0300, 64'd0, 8'h00);
      @(negedge clk);
      chk("t5_c_gnt", 64'(c_gnt), 64'd1);
      tick();
      idle();
      tick();
      rstn = 1'b0;
      c_req = 1'b1;
      @(negedge clk);
      chk("t5_rst_c_gnt", 64'(c_gnt), 64'd0);
      chk("t5_rst_c_stall", 64'(c_stall), 64'd0);
      tick();
      rstn = 1'b1;
      c_req = 1'b0;
      @(negedge clk);
      chk("t5_m_en", 64'(m_en), 64'd0);
      chk("t5_m_wea", 64'(m_wea), 64'd0);
      chk("t5_m_addr", 64'(m_addr), 64'd0);
      chk("t5_m_dina", 64'(m_dina), 64'd0);
      for (int i = 0; i < 5; i++) tick();

      // Core priority with starvation guard (dut1): loader wins on 16th and
      // 32nd cycle of a continuous tie.
      p_c_req = 1'b1;
      p_l_req = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         chk("prio_c_gnt", 64'(p_c_gnt), 64'(i % 16 != 0));
         chk("prio_l_gnt", 64'(p_l_gnt), 64'(i % 16 == 0));
         tick();
      end
      p_c_req = 1'b0;
      p_l_req = 1'b0;
      tick();

      @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
